// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register with EX-stage operand forwarding and load-use
// hazard detection.
//
// Each cycle the decoded instruction in ID is captured and presented to the
// ALU on the following cycle. The two ALU operands are then patched with the
// newest in-flight result (EX/MEM first, MEM/WB second). When the instruction
// in EX is a load whose destination is read by the instruction in ID, a bubble
// is inserted and loadUseStall_o asks the front end to hold PC and IF/ID.
//
// Update priority at each clock edge:
//   rst > flush_i > stall_i (hold) > load-use (bubble) > load from ID
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   stall_i                  external hold, every register keeps its value
//   flush_i                  squash the instruction entering EX
//   pc_i .. branch_i         decoded ID instruction (operands, immediate,
//                            shamt, ALU op, register numbers, control bits)
//   exMem*_i                 EX/MEM writer (enable, destination, ALU result)
//   memWb*_i                 MEM/WB writer (enable, destination, data)
//   a_o, readData2_o         forwarded ALU operands
//   signExtendedOutput_o     registered immediate
//   shiftAmount_o            registered shamt
//   aluCtrl_o                registered ALU op, NOP_CTRL in a bubble
//   aluSrc_o .. memToReg_o   registered control
//   destReg_o                registered destination (rd or rt)
//   pc_o                     registered PC+4
//   valid_o                  1 = real instruction, 0 = bubble
//   loadUseStall_o           combinational hold request for PC and IF/ID
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int                WIDTH    = 32,
    parameter int                RA_W     = 5,
    parameter int                CTRL_W   = 6,
    parameter logic [CTRL_W-1:0] NOP_CTRL = 6'b111100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  pc_i,
    input  logic [WIDTH-1:0]  readData1_i,
    input  logic [WIDTH-1:0]  readData2_i,
    input  logic [WIDTH-1:0]  signExtended_i,
    input  logic [4:0]        shiftAmount_i,
    input  logic [CTRL_W-1:0] aluCtrl_i,
    input  logic [RA_W-1:0]   rs_i,
    input  logic [RA_W-1:0]   rt_i,
    input  logic [RA_W-1:0]   rd_i,
    input  logic              aluSrc_i,
    input  logic              regDst_i,
    input  logic              regWrite_i,
    input  logic              memRead_i,
    input  logic              memWrite_i,
    input  logic              memToReg_i,
    input  logic              branch_i,
    input  logic              exMemRegWrite_i,
    input  logic [RA_W-1:0]   exMemRd_i,
    input  logic [WIDTH-1:0]  exMemAluResult_i,
    input  logic              memWbRegWrite_i,
    input  logic [RA_W-1:0]   memWbRd_i,
    input  logic [WIDTH-1:0]  memWbData_i,
    output logic [WIDTH-1:0]  a_o,
    output logic [WIDTH-1:0]  readData2_o,
    output logic [WIDTH-1:0]  signExtendedOutput_o,
    output logic [4:0]        shiftAmount_o,
    output logic [CTRL_W-1:0] aluCtrl_o,
    output logic              aluSrc_o,
    output logic              tempBranch_o,
    output logic              regWrite_o,
    output logic              memRead_o,
    output logic              memWrite_o,
    output logic              memToReg_o,
    output logic [RA_W-1:0]   destReg_o,
    output logic [WIDTH-1:0]  pc_o,
    output logic              valid_o,
    output logic              loadUseStall_o
);

    // Pipeline state
    logic [WIDTH-1:0]  pc_q,   pc_d;
    logic [WIDTH-1:0]  rd1_q,  rd1_d;
    logic [WIDTH-1:0]  rd2_q,  rd2_d;
    logic [WIDTH-1:0]  imm_q,  imm_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic [RA_W-1:0]   rs_q,   rs_d;
    logic [RA_W-1:0]   rt_q,   rt_d;
    logic [RA_W-1:0]   dest_q, dest_d;
    logic              alu_src_q,   alu_src_d;
    logic              branch_q,    branch_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              valid_q,     valid_d;

    logic load_use;
    logic wb_byp_rs, wb_byp_rt;
    logic ex_fwd_a, wb_fwd_a, ex_fwd_b, wb_fwd_b;

    // A load in EX whose destination is read by ID cannot be forwarded in
    // time; the ID instruction must wait one cycle. Suppressed while the
    // whole pipe is frozen, since nothing advances anyway.
    assign load_use = ~stall_i & valid_q & mem_read_q & (dest_q != '0)
                    & ((dest_q == rs_i) | (dest_q == rt_i));

    // The register file is written on the same edge we capture, so the read
    // in ID still sees the old value; take the writeback data directly.
    assign wb_byp_rs = memWbRegWrite_i & (memWbRd_i != '0) & (memWbRd_i == rs_i);
    assign wb_byp_rt = memWbRegWrite_i & (memWbRd_i != '0) & (memWbRd_i == rt_i);

    always_comb begin
        pc_d         = pc_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        shamt_d      = shamt_q;
        alu_ctrl_d   = alu_ctrl_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        dest_d       = dest_q;
        alu_src_d    = alu_src_q;
        branch_d     = branch_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        valid_d      = valid_q;

        if (flush_i || (!stall_i && load_use)) begin
            // Bubble: kill every side effect; datapath fields keep stale
            // values, which is harmless because nothing commits.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
            alu_ctrl_d  = NOP_CTRL;
        end else if (!stall_i) begin
            pc_d         = pc_i;
            rd1_d        = wb_byp_rs ? memWbData_i : readData1_i;
            rd2_d        = wb_byp_rt ? memWbData_i : readData2_i;
            imm_d        = signExtended_i;
            shamt_d      = shiftAmount_i;
            alu_ctrl_d   = aluCtrl_i;
            rs_d         = rs_i;
            rt_d         = rt_i;
            dest_d       = regDst_i ? rd_i : rt_i;
            alu_src_d    = aluSrc_i;
            branch_d     = branch_i;
            reg_write_d  = regWrite_i;
            mem_read_d   = memRead_i;
            mem_write_d  = memWrite_i;
            mem_to_reg_d = memToReg_i;
            valid_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            alu_ctrl_q   <= NOP_CTRL;
            rs_q         <= '0;
            rt_q         <= '0;
            dest_q       <= '0;
            alu_src_q    <= 1'b0;
            branch_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            shamt_q      <= shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dest_q       <= dest_d;
            alu_src_q    <= alu_src_d;
            branch_q     <= branch_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            valid_q      <= valid_d;
        end
    end

    // EX forwarding; EX/MEM holds the younger result so it wins. $0 is
    // hard-wired zero and never forwarded.
    assign ex_fwd_a = exMemRegWrite_i & (exMemRd_i != '0) & (exMemRd_i == rs_q);
    assign wb_fwd_a = memWbRegWrite_i & (memWbRd_i != '0) & (memWbRd_i == rs_q);
    assign ex_fwd_b = exMemRegWrite_i & (exMemRd_i != '0) & (exMemRd_i == rt_q);
    assign wb_fwd_b = memWbRegWrite_i & (memWbRd_i != '0) & (memWbRd_i == rt_q);

    assign a_o         = ex_fwd_a ? exMemAluResult_i : (wb_fwd_a ? memWbData_i : rd1_q);
    assign readData2_o = ex_fwd_b ? exMemAluResult_i : (wb_fwd_b ? memWbData_i : rd2_q);

    assign signExtendedOutput_o = imm_q;
    assign shiftAmount_o        = shamt_q;
    assign aluCtrl_o            = alu_ctrl_q;
    assign aluSrc_o             = alu_src_q;
    assign tempBranch_o         = branch_q;
    assign regWrite_o           = reg_write_q;
    assign memRead_o            = mem_read_q;
    assign memWrite_o           = mem_write_q;
    assign memToReg_o           = mem_to_reg_q;
    assign destReg_o            = dest_q;
    assign pc_o                 = pc_q;
    assign valid_o              = valid_q;
    assign loadUseStall_o       = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [5:0] NOP = 6'b111100;

    typedef struct {
        logic        rst, stall, flush;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  shamt;
        logic [5:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic        aluSrc, regDst, regWrite, memRead, memWrite, memToReg, branch;
        logic        exRW;
        logic [4:0]  exRd;
        logic [31:0] exRes;
        logic        mwRW;
        logic [4:0]  mwRd;
        logic [31:0] mwData;
    } in_t;

    // Instruction currently sitting in EX, as the reference model sees it.
    // dp = datapath fields are defined (false after a bubble).
    typedef struct {
        logic        valid, dp;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  shamt;
        logic [5:0]  ctrl;
        logic [4:0]  rs, rt, dest;
        logic        aluSrc, branch, regWrite, memRead, memWrite, memToReg;
    } ex_t;

    typedef struct {
        logic        dp;
        logic        valid, regWrite, memRead, memWrite, branch, lus, aluSrc, memToReg;
        logic [5:0]  ctrl;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  shamt, dest;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall_i, flush_i;
    logic [31:0] pc_i, readData1_i, readData2_i, signExtended_i;
    logic [4:0]  shiftAmount_i;
    logic [5:0]  aluCtrl_i;
    logic [4:0]  rs_i, rt_i, rd_i;
    logic        aluSrc_i, regDst_i, regWrite_i, memRead_i, memWrite_i, memToReg_i, branch_i;
    logic        exMemRegWrite_i;
    logic [4:0]  exMemRd_i;
    logic [31:0] exMemAluResult_i;
    logic        memWbRegWrite_i;
    logic [4:0]  memWbRd_i;
    logic [31:0] memWbData_i;
    logic [31:0] a_o, readData2_o, signExtendedOutput_o, pc_o;
    logic [4:0]  shiftAmount_o, destReg_o;
    logic [5:0]  aluCtrl_o;
    logic        aluSrc_o, tempBranch_o, regWrite_o, memRead_o, memWrite_o, memToReg_o;
    logic        valid_o, loadUseStall_o;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .pc_i(pc_i), .readData1_i(readData1_i), .readData2_i(readData2_i),
        .signExtended_i(signExtended_i), .shiftAmount_i(shiftAmount_i),
        .aluCtrl_i(aluCtrl_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .aluSrc_i(aluSrc_i), .regDst_i(regDst_i), .regWrite_i(regWrite_i),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i), .memToReg_i(memToReg_i),
        .branch_i(branch_i),
        .exMemRegWrite_i(exMemRegWrite_i), .exMemRd_i(exMemRd_i),
        .exMemAluResult_i(exMemAluResult_i),
        .memWbRegWrite_i(memWbRegWrite_i), .memWbRd_i(memWbRd_i),
        .memWbData_i(memWbData_i),
        .a_o(a_o), .readData2_o(readData2_o),
        .signExtendedOutput_o(signExtendedOutput_o), .shiftAmount_o(shiftAmount_o),
        .aluCtrl_o(aluCtrl_o), .aluSrc_o(aluSrc_o), .tempBranch_o(tempBranch_o),
        .regWrite_o(regWrite_o), .memRead_o(memRead_o), .memWrite_o(memWrite_o),
        .memToReg_o(memToReg_o), .destReg_o(destReg_o), .pc_o(pc_o),
        .valid_o(valid_o), .loadUseStall_o(loadUseStall_o)
    );

    exp_t sb[$];
    ex_t  m;
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model ----------------
    // Value an ALU operand receives: the newest pending write to that register
    // wins, then the value captured at decode. $0 is always the captured value.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] captured, input in_t x);
        if (x.exRW && x.exRd != 0 && x.exRd == r) return x.exRes;
        if (x.mwRW && x.mwRd != 0 && x.mwRd == r) return x.mwData;
        return captured;
    endfunction

    function automatic logic [31:0] regread(input logic [4:0] r, input logic [31:0] file_val, input in_t x);
        if (x.mwRW && x.mwRd != 0 && x.mwRd == r) return x.mwData;
        return file_val;
    endfunction

    function automatic logic hazard(input ex_t s, input in_t x);
        return !x.stall && s.valid && s.memRead && s.dest != 0 &&
               (s.dest == x.rs || s.dest == x.rt);
    endfunction

    function automatic exp_t expect_of(input ex_t s, input in_t x);
        exp_t e;
        e.dp = s.dp;
        e.valid = s.valid; e.regWrite = s.regWrite; e.memRead = s.memRead;
        e.memWrite = s.memWrite; e.branch = s.branch; e.ctrl = s.ctrl;
        e.lus = hazard(s, x);
        e.a = operand(s.rs, s.rd1, x);
        e.b = operand(s.rt, s.rd2, x);
        e.imm = s.imm; e.pc = s.pc; e.shamt = s.shamt; e.dest = s.dest;
        e.aluSrc = s.aluSrc; e.memToReg = s.memToReg;
        return e;
    endfunction

    function automatic ex_t next_of(input ex_t s, input in_t x);
        ex_t n = s;
        if (x.rst) begin
            n.valid = 0; n.dp = 1; n.pc = 0; n.rd1 = 0; n.rd2 = 0; n.imm = 0;
            n.shamt = 0; n.ctrl = NOP; n.rs = 0; n.rt = 0; n.dest = 0;
            n.aluSrc = 0; n.branch = 0; n.regWrite = 0; n.memRead = 0;
            n.memWrite = 0; n.memToReg = 0;
        end else if (x.flush || hazard(s, x)) begin
            n.valid = 0; n.dp = 0; n.regWrite = 0; n.memRead = 0;
            n.memWrite = 0; n.branch = 0; n.ctrl = NOP;
        end else if (!x.stall) begin
            n.valid = 1; n.dp = 1; n.pc = x.pc;
            n.rd1 = regread(x.rs, x.rd1, x); n.rd2 = regread(x.rt, x.rd2, x);
            n.imm = x.imm; n.shamt = x.shamt; n.ctrl = x.ctrl;
            n.rs = x.rs; n.rt = x.rt; n.dest = x.regDst ? x.rd : x.rt;
            n.aluSrc = x.aluSrc; n.branch = x.branch; n.regWrite = x.regWrite;
            n.memRead = x.memRead; n.memWrite = x.memWrite; n.memToReg = x.memToReg;
        end
        return n;
    endfunction

    // ---------------- stimulus ----------------
    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.rst = ($urandom_range(0, 79) == 0);
        x.stall = ($urandom_range(0, 5) == 0);
        x.flush = ($urandom_range(0, 9) == 0);
        x.pc = $urandom; x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
        x.shamt = 5'($urandom); x.ctrl = 6'($urandom);
        x.rs = pick_reg(); x.rt = pick_reg(); x.rd = pick_reg();
        x.aluSrc = 1'($urandom); x.regDst = 1'($urandom); x.regWrite = 1'($urandom);
        x.memRead = 1'($urandom); x.memWrite = 1'($urandom);
        x.memToReg = 1'($urandom); x.branch = 1'($urandom);
        x.exRW = 1'($urandom); x.exRd = pick_reg(); x.exRes = $urandom;
        x.mwRW = 1'($urandom); x.mwRd = pick_reg(); x.mwData = $urandom;
        return x;
    endfunction

    function automatic in_t base();
        in_t x;
        x.rst = 0; x.stall = 0; x.flush = 0;
        x.pc = 32'h100; x.rd1 = 0; x.rd2 = 0; x.imm = 32'h4; x.shamt = 0;
        x.ctrl = 6'h20; x.rs = 0; x.rt = 0; x.rd = 0;
        x.aluSrc = 0; x.regDst = 1; x.regWrite = 1; x.memRead = 0;
        x.memWrite = 0; x.memToReg = 0; x.branch = 0;
        x.exRW = 0; x.exRd = 0; x.exRes = 0; x.mwRW = 0; x.mwRd = 0; x.mwData = 0;
        return x;
    endfunction

    task automatic drive(input in_t x);
        rst = x.rst; stall_i = x.stall; flush_i = x.flush;
        pc_i = x.pc; readData1_i = x.rd1; readData2_i = x.rd2;
        signExtended_i = x.imm; shiftAmount_i = x.shamt; aluCtrl_i = x.ctrl;
        rs_i = x.rs; rt_i = x.rt; rd_i = x.rd;
        aluSrc_i = x.aluSrc; regDst_i = x.regDst; regWrite_i = x.regWrite;
        memRead_i = x.memRead; memWrite_i = x.memWrite;
        memToReg_i = x.memToReg; branch_i = x.branch;
        exMemRegWrite_i = x.exRW; exMemRd_i = x.exRd; exMemAluResult_i = x.exRes;
        memWbRegWrite_i = x.mwRW; memWbRd_i = x.mwRd; memWbData_i = x.mwData;
    endtask

    // Drive one cycle's inputs; the expected outputs for this cycle go to the
    // scoreboard and the model advances as the DUT will at the next edge.
    task automatic step(input in_t x);
        @(posedge clk);
        #1;
        drive(x);
        sb.push_back(expect_of(m, x));
        m = next_of(m, x);
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("valid_o",        32'(valid_o),        32'(e.valid));
                chk("regWrite_o",     32'(regWrite_o),     32'(e.regWrite));
                chk("memRead_o",      32'(memRead_o),      32'(e.memRead));
                chk("memWrite_o",     32'(memWrite_o),     32'(e.memWrite));
                chk("tempBranch_o",   32'(tempBranch_o),   32'(e.branch));
                chk("aluCtrl_o",      32'(aluCtrl_o),      32'(e.ctrl));
                chk("loadUseStall_o", 32'(loadUseStall_o), 32'(e.lus));
                if (e.dp) begin
                    chk("a_o",         a_o,                   e.a);
                    chk("readData2_o", readData2_o,           e.b);
                    chk("imm_o",       signExtendedOutput_o,  e.imm);
                    chk("pc_o",        pc_o,                  e.pc);
                    chk("shamt_o",     32'(shiftAmount_o),    32'(e.shamt));
                    chk("destReg_o",   32'(destReg_o),        32'(e.dest));
                    chk("aluSrc_o",    32'(aluSrc_o),         32'(e.aluSrc));
                    chk("memToReg_o",  32'(memToReg_o),       32'(e.memToReg));
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        in_t x;
        // Garbage inputs under reset; DUT state is unknown until the first edge.
        x = rnd_in(); x.rst = 1; x.stall = 1; x.flush = 0;
        drive(x);
        m = next_of(m, x);
        x = rnd_in(); x.rst = 1; step(x);
        x = rnd_in(); x.rst = 1; x.memRead = 1; step(x);

        // Forwarding priority on operand A
        x = base(); x.rs = 8; x.rd1 = 32'h11; step(x);
        x = base(); x.stall = 1; step(x);
        x = base(); x.stall = 1; x.exRW = 1; x.exRd = 8; x.exRes = 32'hAA; step(x);
        x.mwRW = 1; x.mwRd = 8; x.mwData = 32'hBB; step(x);

        // Load-use: lw $9 then a reader of $9
        x = base(); x.memRead = 1; x.memToReg = 1; x.regDst = 0; x.rt = 9; x.rs = 2; step(x);
        x = base(); x.rs = 3; x.rt = 9; x.rd = 10; x.rd2 = 32'h55; step(x);
        step(x);
        x = base(); step(x);

        // External stall while ID keeps changing, then release
        x = base(); x.rs = 1; x.rd1 = 32'h1234; x.pc = 32'h200; step(x);
        for (int i = 0; i < 3; i++) begin
            x = rnd_in(); x.rst = 0; x.flush = 0; x.stall = 1; step(x);
        end
        x = base(); x.pc = 32'h300; x.rd1 = 32'h77; x.rs = 2; step(x);
        x = base(); step(x);

        // Flush with a valid add in ID
        x = base(); x.flush = 1; x.branch = 1; x.rd = 4; step(x);
        x = base(); step(x);

        // $0 is never forwarded; MEM/WB bypass at capture
        x = base(); x.rs = 0; x.rd1 = 0; step(x);
        x = base(); x.stall = 1; x.exRW = 1; x.exRd = 0; x.exRes = 32'hDEAD; step(x);
        x = base(); x.rs = 5; x.rd1 = 32'h1; x.mwRW = 1; x.mwRd = 5; x.mwData = 32'h77; step(x);
        x = base(); x.stall = 1; step(x);

        // Random traffic
        for (int i = 0; i < 2000; i++) step(rnd_in());

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
